mdu_ctrl: RTL
=============

// Module: mdu_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the pipelined MIPS core, sitting in the E stage.
//  Latches operands on start, holds busy for a fixed MULT/DIV latency, then commits HI/LO.
//  Raises stall to the hazard unit when a HI/LO instruction arrives while an op is pending.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-low: 0 = reset asserted
//  start     in   1   E-stage mult/multu/div/divu issue, one-cycle pulse
//  op        in   2   00 mult, 01 multu, 10 div, 11 divu (valid with start)
//  src_a     in   32  rs operand (valid with start)
//  src_b     in   32  rt operand (valid with start)
//  mthi      in   1   write mt_data to HI
//  mtlo      in   1   write mt_data to LO
//  mt_data   in   32  mthi/mtlo data
//  hilo_req  in   1   D-stage instr uses HI/LO (mult/div/mf/mt)
//  flush     in   1   abort in-flight op (only with MDU_CANCEL_EN)
//  busy      out  1   op in flight
//  stall     out  1   hazard stall request
//  done      out  1   one-cycle pulse, HI/LO committed this edge
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  Reset (reset=0, any time): state IDLE, cnt=0; busy, done, hi, lo = 0; in-flight op dropped, no commit.
//  FSM: IDLE -> RUN on start (latch op, result, cnt = N-1; N = MULT_CYCLES or DIV_CYCLES).
//       RUN: cnt-- each cycle; at cnt==0 commit HI/LO, pulse done, -> IDLE.
//  Timing: start sampled at edge t -> busy=1 for cycles t+1..t+N; commit at edge t+N; new HI/LO visible from t+N.
//  Back-to-back: start accepted in the cycle done pulses (same as IDLE).
//  start while busy: ignored (the pipeline must have stalled it).
//  mthi/mtlo: write accepted only when IDLE and start=0; otherwise dropped. mthi and mtlo together write both.
//  stall = hilo_req & (busy | start), combinational; deasserts in the commit cycle's successor.
//  Arithmetic: mult/multu 64-bit product {hi,lo}, signed or unsigned per op.
//   div: lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
//   divu: unsigned. 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
//  Divide by zero: op still takes DIV_CYCLES and pulses done; HI/LO are left unchanged.
// CONFIGURATION
//  MDU_CANCEL_EN defined: flush=1 forces IDLE at the next edge, busy=0, no commit, no done.
//   flush has priority over start and over a commit in the same cycle.
//  MDU_CANCEL_EN undefined: flush port exists but is ignored; ops always run to completion.
// STRUCTURE
//  mdu_pkg: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), state enum {IDLE, RUN}.
//   Also holds default latency constants.
//  Sub-module mdu_arith: combinational 64-bit {hi,lo} result plus a div0 flag from op/src_a/src_b.
//   Evaluated at start; mdu_ctrl registers the result.
//  mdu_ctrl holds the FSM, counter, HI/LO registers and stall logic.
// TESTING
//  1. mult 0xFFFFFFFF*0x2 -> busy 5 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  2. multu 0xFFFFFFFF*0x2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//  3. div 0xFFFFFFF9(-7)/2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     Then divu 7/0 -> HI/LO unchanged, done still pulses.
//  4. hilo_req=1 from start cycle (mfhi behind mult) -> stall=1 in exactly 6 cycles (start + 5 busy).
//     stall=0 when the new hi is readable. mthi 0x1234 during busy -> dropped.
//  5. reset=0 at busy cycle 3 of div -> busy=0, hi=lo=0 immediately; no done after reset release.
//  6. MDU_CANCEL_EN: flush at busy cycle 2 of mult -> busy=0 next edge, HI/LO keep old values.
//     Without the macro: same stimulus completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and default latencies shared by the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational {hi,lo} result of mult/multu/div/divu plus a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic [63:0] res_o,
  output logic        div0_o
);
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, div_b, quo, rem;
  logic        sdiv, b_zero;
  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
  always_comb begin
    sdiv   = op_i == MDU_DIV;
    b_zero = src_b_i == '0;
    mag_a  = sdiv && src_a_i[31] ? -src_a_i : src_a_i;
    mag_b  = sdiv && src_b_i[31] ? -src_b_i : src_b_i;
    div_b  = b_zero ? 32'd1 : mag_b;
    quo    = mag_a / div_b;
    rem    = mag_a % div_b;
    prod_s = {{32{src_a_i[31]}}, src_a_i} * {{32{src_b_i[31]}}, src_b_i};
    prod_u = {32'b0, src_a_i} * {32'b0, src_b_i};
    res_o  = op_i == MDU_MULT  ? prod_s :
             op_i == MDU_MULTU ? prod_u :
             {sdiv && src_a_i[31] ? -rem : rem,
              sdiv && (src_a_i[31] ^ src_b_i[31]) ? -quo : quo};
    div0_o = op_i[1] & b_zero;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer with HI/LO registers and hazard stall.
// Define MDU_CANCEL_EN to let flush_i abort an in-flight op.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] mt_data_i,
  input  logic        hilo_req_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int MAXN = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = MAXN > 1 ? $clog2(MAXN) : 1;

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     res_q, res_d, ar_res;
  logic            div0_q, div0_d, ar_div0;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            cancel, commit, accept, mt_ok;

  mdu_arith u_arith (
    .op_i    (mdu_op_e'(op_i)),
    .src_a_i (src_a_i),
    .src_b_i (src_b_i),
    .res_o   (ar_res),
    .div0_o  (ar_div0)
  );

`ifdef MDU_CANCEL_EN
  assign cancel = flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign cancel = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A commit cycle behaves like IDLE for a new start, giving back-to-back issue.
  always_comb begin
    commit  = state_q == RUN && cnt_q == '0 && !cancel;
    accept  = start_i && !cancel && (state_q == IDLE || commit);
    mt_ok   = state_q == IDLE && !start_i;
    state_d = cancel ? IDLE : accept ? RUN : commit ? IDLE : state_q;
    cnt_d   = accept ? (op_i[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1)) :
              state_q == RUN && !commit && !cancel ? cnt_q - CW'(1) : '0;
    res_d   = accept ? ar_res : res_q;
    div0_d  = accept ? ar_div0 : div0_q;
    hi_d    = commit && !div0_q ? res_q[63:32] : mt_ok && mthi_i ? mt_data_i : hi_q;
    lo_d    = commit && !div0_q ? res_q[31:0]  : mt_ok && mtlo_i ? mt_data_i : lo_q;
  end

  always_comb begin
    busy_o  = state_q == RUN;
    done_o  = commit;
    stall_o = hilo_req_i & (busy_o | start_i);
    hi_o    = hi_q;
    lo_o    = lo_q;
  end
endmodule
